// File: rtl/game_phase_ctrl.sv
// game_phase_ctrl: game-phase sequencer for the mole game.
//
// Runs the READY countdown, the timed PLAY round, score accounting and the
// GAME_OVER / GAME_CLEAR end states. A prescaler divides clk down to one
// sec_tick per game second.
//
// Optional feature macro: GAME_PAUSE_EN adds pause_btn and the PAUSED phase (110).
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset
//   start_btn      start button level (debounced, synchronous)
//   pause_btn      pause button level (only with GAME_PAUSE_EN)
//   hit            one-cycle pulse per successful hit
//   state          phase code: 000 IDLE, 001 READY, 010 PLAY, 011 OVER, 101 CLEAR, 110 PAUSED
//   timer_running  1 while a countdown is active
//   timer          seconds remaining in the current countdown
//   score          hit count for the current round
//   sec_tick       one-cycle pulse on each game-second boundary
module game_phase_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned READY_SECS    = 3,
  parameter int unsigned PLAY_SECS     = 60,
  parameter int unsigned TARGET_SCORE  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
`ifdef GAME_PAUSE_EN
  input  logic       pause_btn,
`endif
  input  logic       hit,
  output logic [2:0] state,
  output logic       timer_running,
  output logic [6:0] timer,
  output logic [6:0] score,
  output logic       sec_tick
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PrescMax  = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    ReadyInit = 7'(READY_SECS);
  localparam logic [6:0]    PlayInit  = 7'(PLAY_SECS);
  localparam logic [7:0]    Target    = 8'(TARGET_SCORE);

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StReady  = 3'b001,
    StPlay   = 3'b010,
    StOver   = 3'b011,
    StClear  = 3'b101,
    StPaused = 3'b110
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    timer_q, timer_d;
  logic [6:0]    score_q, score_d;
  logic          run_q, run_d;
  logic          tick_q, tick_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_prev_q;
  logic          start_ev;
  logic          pause_ev;
  logic          wrap;
  logic [7:0]    score_sum;
  logic [6:0]    score_sat;

  assign start_ev  = start_btn & ~start_prev_q;
  assign wrap      = (presc_q == PrescMax);
  assign score_sum = {1'b0, score_q} + {7'b0, hit};
  assign score_sat = score_sum[7] ? 7'h7f : score_sum[6:0];

`ifdef GAME_PAUSE_EN
  logic pause_prev_q;
  assign pause_ev = pause_btn & ~pause_prev_q;

  always_ff @(posedge clk) begin
    if (rst) pause_prev_q <= 1'b1;
    else     pause_prev_q <= pause_btn;
  end
`else
  assign pause_ev = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    run_d   = run_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    case (state_q)
      StIdle, StOver, StClear: begin
        presc_d = '0;
        if (state_q == StIdle) run_d = 1'b0;
        if (start_ev) begin
          state_d = StReady;
          timer_d = ReadyInit;
          run_d   = 1'b1;
          score_d = '0;
        end
      end
      StReady: begin
        tick_d = wrap;
        if (wrap) begin
          presc_d = '0;
          // Timer sits at 0 for one extra second before PLAY starts.
          if (timer_q == '0) begin
            state_d = StPlay;
            timer_d = PlayInit;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StPlay: begin
        if (pause_ev) begin
          state_d = StPaused;
          run_d   = 1'b0;
        end else begin
          tick_d  = wrap;
          score_d = score_sat;
          // Reaching the target beats a simultaneous final tick.
          if (score_sum >= Target) begin
            state_d = StClear;
            run_d   = 1'b0;
            presc_d = '0;
          end else if (wrap) begin
            presc_d = '0;
            if (timer_q <= 7'd1) begin
              state_d = StOver;
              timer_d = '0;
              run_d   = 1'b0;
            end else begin
              timer_d = timer_q - 7'd1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
`ifdef GAME_PAUSE_EN
      StPaused: begin
        // Prescaler is deliberately kept so the interrupted second resumes.
        if (pause_ev) begin
          state_d = StPlay;
          run_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        run_d   = 1'b0;
        presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      score_q      <= '0;
      run_q        <= 1'b0;
      tick_q       <= 1'b0;
      presc_q      <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      run_q        <= run_d;
      tick_q       <= tick_d;
      presc_q      <= presc_d;
      start_prev_q <= start_btn;
    end
  end

  assign state         = state_q;
  assign timer         = timer_q;
  assign score         = score_q;
  assign timer_running = run_q;
  assign sec_tick      = tick_q;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Testbench for game_phase_ctrl: directed scenarios plus random stimulus, every
// cycle compared against a model that derives the countdown from elapsed time.
module tb_game_phase_ctrl;
  localparam int T  = 4;
  localparam int RS = 2;
  localparam int PS = 3;
  localparam int TS = 2;

  localparam int PhIdle  = 0;
  localparam int PhReady = 1;
  localparam int PhPlay  = 2;
  localparam int PhOver  = 3;
  localparam int PhClear = 5;
  localparam int PhPause = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b1;
  logic       hit = 1'b0;
`ifdef GAME_PAUSE_EN
  logic       pause_btn = 1'b1;
`endif
  logic [2:0] state;
  logic       timer_running;
  logic [6:0] timer;
  logic [6:0] score;
  logic       sec_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase plus active cycles elapsed in the phase.
  int m_state, m_timer, m_run, m_score, m_tick, m_act, m_sprev, m_pprev;

  game_phase_ctrl #(
    .TICKS_PER_SEC(T),
    .READY_SECS   (RS),
    .PLAY_SECS    (PS),
    .TARGET_SCORE (TS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
`ifdef GAME_PAUSE_EN
    .pause_btn    (pause_btn),
`endif
    .hit          (hit),
    .state        (state),
    .timer_running(timer_running),
    .timer        (timer),
    .score        (score),
    .sec_tick     (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int sev, pev, secs, sum;
    if (rst) begin
      m_state = PhIdle; m_timer = 0; m_run = 0; m_score = 0;
      m_tick = 0; m_act = 0; m_sprev = 1; m_pprev = 1;
      return;
    end
    sev = (start_btn && !m_sprev) ? 1 : 0;
    m_sprev = int'(start_btn);
`ifdef GAME_PAUSE_EN
    pev = (pause_btn && !m_pprev) ? 1 : 0;
    m_pprev = int'(pause_btn);
`else
    pev = 0;
`endif
    m_tick = 0;
    case (m_state)
      PhIdle, PhOver, PhClear: begin
        if (sev != 0) begin
          m_state = PhReady; m_act = 0; m_timer = RS; m_run = 1; m_score = 0;
        end
      end
      PhReady: begin
        m_act++;
        m_tick = (m_act % T == 0) ? 1 : 0;
        secs = m_act / T;
        if (secs == RS + 1) begin
          m_state = PhPlay; m_act = 0; m_timer = PS;
        end else begin
          m_timer = RS - secs;
        end
      end
      PhPlay: begin
        if (pev != 0) begin
          m_state = PhPause; m_run = 0;
        end else begin
          m_act++;
          m_tick = (m_act % T == 0) ? 1 : 0;
          sum = m_score + int'(hit);
          m_score = (sum > 127) ? 127 : sum;
          if (sum >= TS) begin
            m_state = PhClear; m_run = 0;
          end else begin
            m_timer = PS - m_act / T;
            if (m_timer == 0) begin
              m_state = PhOver; m_run = 0;
            end
          end
        end
      end
      PhPause: begin
        if (pev != 0) begin
          m_state = PhPlay; m_run = 1;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: update the model on the edge, compare just after it.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state", int'(state), m_state);
    check_eq("timer", int'(timer), m_timer);
    check_eq("running", int'(timer_running), m_run);
    check_eq("score", int'(score), m_score);
    check_eq("sec_tick", int'(sec_tick), m_tick);
  endtask

  initial begin
    // Reset with start held: no start until released and pressed again.
    rst = 1'b1; start_btn = 1'b1; hit = 1'b0;
    repeat (3) step();
    rst = 1'b0;
`ifdef GAME_PAUSE_EN
    pause_btn = 1'b0;
`endif
    repeat (4) begin
      step();
      check_eq("t1_idle_state", int'(state), 0);
    end
    check_eq("t1_timer", int'(timer), 0);
    check_eq("t1_score", int'(score), 0);
    check_eq("t1_running", int'(timer_running), 0);
    start_btn = 1'b0; step();
    check_eq("t1_release_state", int'(state), 0);

    // READY countdown timing.
    start_btn = 1'b1; step();
    check_eq("t2_n1_state", int'(state), 1);
    check_eq("t2_n1_timer", int'(timer), 2);
    check_eq("t2_n1_running", int'(timer_running), 1);
    repeat (4) step();
    check_eq("t2_n5_timer", int'(timer), 1);
    repeat (4) step();
    check_eq("t2_n9_timer", int'(timer), 0);
    check_eq("t2_n9_running", int'(timer_running), 1);
    repeat (4) step();
    check_eq("t2_n13_state", int'(state), 2);
    check_eq("t2_n13_timer", int'(timer), 3);
    start_btn = 1'b0;

    // Two hits reach the target; timer frozen afterwards.
    hit = 1'b1; step(); hit = 1'b0; step();
    hit = 1'b1; step(); hit = 1'b0;
    check_eq("t3_state", int'(state), 5);
    check_eq("t3_score", int'(score), 2);
    check_eq("t3_running", int'(timer_running), 0);
    check_eq("t3_timer", int'(timer), 3);
    repeat (10) step();
    check_eq("t3_frozen_timer", int'(timer), 3);
    check_eq("t3_hold_state", int'(state), 5);

    // Restart from CLEAR, then let the round time out.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    check_eq("t4_restart_state", int'(state), 1);
    check_eq("t4_restart_score", int'(score), 0);
    repeat (12) step();
    check_eq("t4_play_state", int'(state), 2);
    repeat (12) step();
    check_eq("t4_over_state", int'(state), 3);
    check_eq("t4_over_timer", int'(timer), 0);
    check_eq("t4_over_running", int'(timer_running), 0);
    check_eq("t4_over_score", int'(score), 0);
    start_btn = 1'b1; step(); start_btn = 1'b0;
    check_eq("t4_again_state", int'(state), 1);
    check_eq("t4_again_timer", int'(timer), 2);
    check_eq("t4_again_score", int'(score), 0);

    // Final hit coincides with the final tick: CLEAR wins.
    repeat (12) step();
    hit = 1'b1; step(); hit = 1'b0;
    repeat (10) step();
    check_eq("t5_pre_timer", int'(timer), 1);
    check_eq("t5_pre_score", int'(score), 1);
    hit = 1'b1; step(); hit = 1'b0;
    check_eq("t5_clear_state", int'(state), 5);

    // Reset in the middle of PLAY.
    start_btn = 1'b1; step(); start_btn = 1'b0;
    repeat (12) step();
    hit = 1'b1; step(); hit = 1'b0;
    repeat (4) step();
    check_eq("t6_pre_timer", int'(timer), 2);
    check_eq("t6_pre_score", int'(score), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_eq("t6_rst_state", int'(state), 0);
    check_eq("t6_rst_timer", int'(timer), 0);
    check_eq("t6_rst_score", int'(score), 0);
    check_eq("t6_rst_running", int'(timer_running), 0);

`ifdef GAME_PAUSE_EN
    // Pause freezes PLAY; resume keeps the partial second.
    pause_btn = 1'b0;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    repeat (12) step();
    repeat (2) step();
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check_eq("tp_paused_state", int'(state), 6);
    check_eq("tp_paused_running", int'(timer_running), 0);
    repeat (20) begin
      hit = 1'b1; step(); hit = 1'b0;
      check_eq("tp_frozen_timer", int'(timer), 3);
    end
    check_eq("tp_frozen_score", int'(score), 0);
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check_eq("tp_resume_state", int'(state), 2);
    repeat (2) step();
    check_eq("tp_resume_timer", int'(timer), 2);
`endif

    // Random traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
      hit = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 399) == 0);
`ifdef GAME_PAUSE_EN
      if ($urandom_range(0, 29) == 0) pause_btn = ~pause_btn;
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
Top-level game-phase sequencer for the mole game. It owns the `state`/`timer_running`/`timer` bundle consumed by the RGB LED output unit. It runs the READY countdown, the timed PLAY round, score accounting and the OVER/CLEAR end states, using a 1 Hz-equivalent tick derived from the system clock by an internal prescaler.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per game second (≥2)
READY_SECS, 3, READY countdown start value (1..127)
PLAY_SECS, 60, PLAY round length in seconds (1..127)
TARGET_SCORE, 20, hits needed for GAME CLEAR (1..127)

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous, active-high reset
start_btn  in  1  start button level; debounced and synchronous upstream
hit  in  1  one-cycle pulse per successful mole hit
state  out  3  phase code: 000 IDLE, 001 READY, 010 PLAY, 011 GAME_OVER, 101 GAME_CLEAR
timer_running  out  1  1 while a countdown is active
timer  out  7  seconds remaining in the current countdown
score  out  7  hit count for the current round
sec_tick  out  1  one-cycle pulse at each game-second boundary

Behaviour:
- Clock/reset: one clock (`clk`); reset `rst` is synchronous and active-high. Reset values: state=000, timer=0, timer_running=0, score=0, sec_tick=0, prescaler=0, start_prev=1.
- Because start_prev resets to 1, a button held through reset does not trigger a start; it must be released and pressed again.
- Start event: `start_btn & ~start_prev`, registered each cycle.
- Prescaler: counts 0..TICKS_PER_SEC-1; sec_tick=1 on the cycle the count wraps.
  - The prescaler clears to 0 on every state change, so the first second of each phase is always full length.
  - The prescaler is held at 0 in IDLE, GAME_OVER and GAME_CLEAR.
- IDLE: timer_running=0. Start event → next cycle: state=001, timer=READY_SECS, timer_running=1, score=0.
- READY: timer decrements on each sec_tick.
  - When timer reaches 0, it holds 0 for one further full second (LED "go" phase), with timer_running still 1.
  - sec_tick while timer==0 → state=010, timer=PLAY_SECS, timer_running=1.
  - READY lasts exactly (READY_SECS+1)×TICKS_PER_SEC cycles.
  - Hits are ignored.
- PLAY:
  - Each hit increments score, saturating at 127.
  - If (score+hit) ≥ TARGET_SCORE → next cycle state=101, timer_running=0, timer frozen at its current value.
  - Otherwise, each sec_tick decrements timer. The decrement that takes timer to 0 moves state to 011 on the same edge, with timer=0 and timer_running=0.
  - Simultaneous final hit and final tick: GAME_CLEAR wins.
  - Start events in PLAY or READY are ignored.
- GAME_OVER / GAME_CLEAR:
  - score, timer and state hold.
  - Start event → READY exactly as from IDLE, including score cleared to 0.
- Latency: every transition is visible on the cycle after the causing event. All outputs are registered.
- rst mid-operation: the next cycle shows all reset values, regardless of phase.
- Encodings 100, 110 and 111 are never produced, except 110 under the optional feature. An illegal state register value recovers to IDLE on the next cycle.

Optional Feature:
GAME_PAUSE_EN:
- Defined:
  - Adds input port `pause_btn` (1 bit, same conditioning as start_btn, prev register resets to 1).
  - A rising edge in PLAY enters PAUSED (state=110, timer_running=0): prescaler, timer and score freeze, and hits are ignored.
  - A rising edge in PAUSED returns to 010 with the prescaler value preserved.
  - pause_btn edges in any other state are ignored.
- Undefined: port absent; code 110 is unreachable.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, READY_SECS=2, PLAY_SECS=3, TARGET_SCORE=2.
1. Assert rst with start_btn held high, then release rst → state=000, timer=0, score=0, running=0; no start until start_btn falls and rises again.
2. Start edge at cycle N:
   - N+1: state=001, timer=2, running=1.
   - N+5: timer=1.
   - N+9: timer=0, running=1.
   - N+13: state=010, timer=3.
3. In PLAY, hit pulses at two separate cycles → cycle after second hit: state=101, score=2, running=0; subsequent sec_ticks do not change timer.
4. In PLAY, no hits → 12 cycles after PLAY entry: state=011, timer=0, running=0, score=0; then start edge → state=001, timer=2, score=0.
5. score=1 and hit coincident with the final sec_tick (timer 1→0) → state=101, not 011.
6. Assert rst mid-PLAY with timer=2, score=1 → next cycle all outputs at reset values. With GAME_PAUSE_EN: pause edge freezes timer for 20 cycles at state=110; a second edge resumes 010 and the timer continues.
